filter_engine: RTL and testbench

FILTER_ENGINE -- requirements
Module: filter_engine

---
 rtl/filter_engine.sv | 224 ++++++++++++++++++++++
 tb/tb_filter_engine.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_engine.sv
// 2x2 convolution engine: reads an MxN byte image and a signed 4-tap mask from memory,
// and writes the shifted, clamped (M-1)x(N-1) result directly after the input image.

module filter_engine #(
    parameter int unsigned BASE_IN = 24,
    parameter int          SHIFT   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        WE,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [7:0]  Din,
    input  logic [31:0] Do,
    input  logic [7:0]  Dob
);

    typedef enum logic [2:0] {
        IDLE,
        HDR_ADDR,
        HDR_CAP,
        PIX_ADDR,
        PIX_CAP,
        CALC,
        WR,
        DONE
    } state_e;

    // Index 6 is the dispatch visit of HDR_ADDR: no read, just the size check.
    localparam logic [2:0] HDR_DISPATCH = 3'd6;

    state_e             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [15:0]        m_q, m_d;
    logic [15:0]        n_q, n_d;
    logic signed [15:0] k_q [4];
    logic signed [15:0] k_d [4];
    logic [15:0]        r_q, r_d;
    logic [15:0]        c_q, c_d;
    logic [1:0]         pk_q, pk_d;
    logic [7:0]         p_q [4];
    logic [7:0]         p_d [4];
    logic [7:0]         res_q, res_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;

    logic [31:0]        pix_addr;
    logic [31:0]        out_addr;
    logic signed [27:0] acc;
    logic signed [27:0] shifted;
    logic [7:0]         clamped;

    logic unused_do_hi;
    assign unused_do_hi = ^Do[31:16];

    // Pk sits at (r + pk[1], c + pk[0]), which yields the P0..P3 read order.
    always_comb begin
        pix_addr = 32'(BASE_IN) + (32'(r_q) + 32'(pk_q[1])) * 32'(n_q)
                 + 32'(c_q) + 32'(pk_q[0]);
        out_addr = 32'(BASE_IN) + 32'(m_q) * 32'(n_q)
                 + 32'(r_q) * (32'(n_q) - 32'd1) + 32'(c_q);
    end

    always_comb begin
        acc = '0;
        for (int i = 0; i < 4; i++) begin
            acc = acc + $signed({20'd0, p_q[i]}) * 28'(k_q[i]);
        end
        shifted = acc >>> SHIFT;
        if (shifted < 28'sd0) begin
            clamped = 8'd0;
        end else if (shifted > 28'sd255) begin
            clamped = 8'd255;
        end else begin
            clamped = shifted[7:0];
        end
    end

    // NOTE: every signal written here gets its default first, so no path through
    // the case statement leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        m_d     = m_q;
        n_d     = n_q;
        k_d     = k_q;
        r_d     = r_q;
        c_d     = c_q;
        pk_d    = pk_q;
        p_d     = p_q;
        res_d   = res_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = HDR_ADDR;
                    idx_d   = 3'd0;
                end
            end
            HDR_ADDR: begin
                if (idx_q == HDR_DISPATCH) begin
                    if (m_q < 16'd2 || n_q < 16'd2) begin
                        state_d = DONE;
                    end else begin
                        state_d = PIX_ADDR;
                        r_d     = '0;
                        c_d     = '0;
                        pk_d    = '0;
                    end
                end else begin
                    state_d = HDR_CAP;
                end
            end
            HDR_CAP: begin
                case (idx_q)
                    3'd0:    m_d = Do[15:0];
                    3'd1:    n_d = Do[15:0];
                    default: k_d[2'(idx_q - 3'd2)] = Do[15:0];
                endcase
                idx_d   = idx_q + 3'd1;
                state_d = HDR_ADDR;
            end
            PIX_ADDR: begin
                state_d = PIX_CAP;
            end
            PIX_CAP: begin
                p_d[pk_q] = Dob;
                if (pk_q == 2'd3) begin
                    state_d = CALC;
                end else begin
                    pk_d    = pk_q + 2'd1;
                    state_d = PIX_ADDR;
                end
            end
            CALC: begin
                res_d   = clamped;
                state_d = WR;
            end
            WR: begin
                pk_d    = '0;
                state_d = PIX_ADDR;
                if (c_q == n_q - 16'd2) begin
                    c_d = '0;
                    if (r_q == m_q - 16'd2) begin
                        state_d = DONE;
                    end else begin
                        r_d = r_q + 16'd1;
                    end
                end else begin
                    c_d = c_q + 16'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A and B track the last driven address so they hold between uses.
    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
        WE   = (state_q != WR);
        Din  = (state_q == WR) ? res_q : 8'd0;

        if (state_q == HDR_ADDR && idx_q != HDR_DISPATCH) begin
            A = {27'd0, idx_q, 2'b00};
        end else begin
            A = a_q;
        end

        if (state_q == PIX_ADDR) begin
            B = pix_addr;
        end else if (state_q == WR) begin
            B = out_addr;
        end else begin
            B = b_q;
        end

        a_d = A;
        b_d = B;
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values;
    // the mask and pixel registers are small enough to reset like any other flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            m_q     <= '0;
            n_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            pk_q    <= '0;
            res_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            for (int i = 0; i < 4; i++) begin
                k_q[i] <= '0;
                p_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            m_q     <= m_d;
            n_q     <= n_d;
            r_q     <= r_d;
            c_q     <= c_d;
            pk_q    <= pk_d;
            res_q   <= res_d;
            a_q     <= a_d;
            b_q     <= b_d;
            k_q     <= k_d;
            p_q     <= p_d;
        end
    end

endmodule

// File: tb/tb_filter_engine.sv
// Bench for filter_engine: two instances (SHIFT=0 and SHIFT=2), each with its own memory
// model; table vectors, reset/abort sequences and randomized passes against a reference model.
`timescale 1ns/1ps

module tb_filter_engine;

    localparam int BASE = 24;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_s [2];
    logic        busy_s  [2];
    logic        done_s  [2];
    logic        we_s    [2];
    logic [31:0] a_s     [2];
    logic [31:0] b_s     [2];
    logic [7:0]  din_s   [2];
    logic [31:0] do_s    [2];
    logic [7:0]  dob_s   [2];

    always #5 clk = ~clk;

    filter_engine #(.BASE_IN(BASE), .SHIFT(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_s[0]), .busy(busy_s[0]), .done(done_s[0]),
        .WE(we_s[0]), .A(a_s[0]), .B(b_s[0]), .Din(din_s[0]), .Do(do_s[0]), .Dob(dob_s[0])
    );

    filter_engine #(.BASE_IN(BASE), .SHIFT(2)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_s[1]), .busy(busy_s[1]), .done(done_s[1]),
        .WE(we_s[1]), .A(a_s[1]), .B(b_s[1]), .Din(din_s[1]), .Do(do_s[1]), .Dob(dob_s[1])
    );

    // Memory model: registered word/byte reads, every WE=0 cycle logged as a write.
    typedef struct {
        int inst;
        int addr;
        int data;
    } wr_t;

    logic [31:0] hdr  [2][8];
    logic [7:0]  pmem [2][256];
    wr_t         wq[$];
    wr_t         exp_q[$];
    int          wq_base;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            do_s[i]  <= hdr[i][a_s[i][4:2]];
            dob_s[i] <= pmem[i][b_s[i][7:0]];
            if (we_s[i] === 1'b0) begin
                wq.push_back('{i, int'(b_s[i]), int'(din_s[i])});
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    int cur_k [4];
    int img   [64];

    task automatic load_and_start(input int inst, input int m, input int n);
        for (int i = 0; i < 256; i++) pmem[inst][i] = 8'hEE;
        for (int i = 0; i < m * n && i < 64; i++) pmem[inst][BASE + i] = 8'(img[i]);
        for (int i = 0; i < 8; i++) hdr[inst][i] = $urandom;
        hdr[inst][0] = {16'($urandom), 16'(m)};
        hdr[inst][1] = {16'($urandom), 16'(n)};
        for (int j = 0; j < 4; j++) hdr[inst][2 + j] = {16'($urandom), 16'(cur_k[j])};
        wq_base = wq.size();
        @(negedge clk);
        start_s[inst] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_s[inst] = 1'b0;
        check("busy_after_start", busy_s[inst], 1);
    endtask

    task automatic wait_done(input int inst, input bit noisy, output int done_cyc);
        int cnt;
        cnt      = 0;
        done_cyc = -1;
        while (cnt < 2000) begin
            @(negedge clk);
            cnt++;
            if (done_s[inst] === 1'b1) begin
                start_s[inst] = 1'b0;
                done_cyc      = cnt;
                break;
            end
            start_s[inst] = noisy && (cnt % 7 == 3);
        end
        if (done_cyc > 0) begin
            check("busy_in_done", busy_s[inst], 1);
            @(negedge clk);
            check("done_pulse_len", done_s[inst], 0);
            check("busy_after_done", busy_s[inst], 0);
        end
    endtask

    task automatic check_pass(input string tag, input int done_cyc, input int exp_done);
        int nw;
        nw = wq.size() - wq_base;
        check({tag, "_done_cycle"}, done_cyc, exp_done);
        check({tag, "_n_writes"}, nw, exp_q.size());
        for (int i = 0; i < nw && i < exp_q.size(); i++) begin
            check($sformatf("%s_wr%0d_inst", tag, i), wq[wq_base + i].inst, exp_q[i].inst);
            check($sformatf("%s_wr%0d_addr", tag, i), wq[wq_base + i].addr, exp_q[i].addr);
            check($sformatf("%s_wr%0d_data", tag, i), wq[wq_base + i].data, exp_q[i].data);
        end
    endtask

    // Reference model: straight from the image grid, one output per 2x2 window.
    function automatic int model(input int inst, input int m, input int n, input int shift);
        int s;
        exp_q.delete();
        if (m < 2 || n < 2) return 13;
        for (int r = 0; r < m - 1; r++) begin
            for (int c = 0; c < n - 1; c++) begin
                s = img[r*n + c] * cur_k[0] + img[r*n + c + 1] * cur_k[1]
                  + img[(r+1)*n + c] * cur_k[2] + img[(r+1)*n + c + 1] * cur_k[3];
                s = s >>> shift;
                if (s < 0) s = 0;
                if (s > 255) s = 255;
                exp_q.push_back('{inst, BASE + m*n + r*(n-1) + c, s});
            end
        end
        return 13 + 10 * (m - 1) * (n - 1);
    endfunction

    typedef struct {
        int               inst;
        int               m, n;
        int               k0, k1, k2, k3;
        logic [5:0][7:0]  px;
        bit               noisy;
        int               nexp;
        int               a0, d0, a1, d1;
        int               done_cyc;
    } vec_t;

    function automatic logic [5:0][7:0] pack6(input int p0, p1, p2, p3, p4, p5);
        logic [5:0][7:0] v;
        v[0] = 8'(p0); v[1] = 8'(p1); v[2] = 8'(p2);
        v[3] = 8'(p3); v[4] = 8'(p4); v[5] = 8'(p5);
        return v;
    endfunction

    localparam int NV = 9;
    vec_t vecs [NV];

    task automatic idle_outputs(input string tag);
        check({tag, "_busy"}, busy_s[0], 0);
        check({tag, "_done"}, done_s[0], 0);
        check({tag, "_we"}, we_s[0], 1);
        check({tag, "_a"}, a_s[0], 0);
        check({tag, "_b"}, b_s[0], 0);
        check({tag, "_din"}, din_s[0], 0);
    endtask

    initial begin
        int dc;
        int ed;
        int m;
        int n;
        int inst;

        //            inst m  n  K0  K1 K2  K3  pixels                     noisy nexp a0 d0   a1 d1   done
        vecs[0] = '{0, 2, 2, 1,  0, 0,  0, pack6(10, 20, 30, 40, 0, 0),     0, 1, 28, 10,  0, 0,   23};
        vecs[1] = '{0, 2, 3, 1,  1, 1,  1, pack6(100,100,100,100,100,100),  1, 2, 30, 255, 31, 255, 33};
        vecs[2] = '{0, 2, 2, -1, 0, 0,  0, pack6(50, 1, 2, 3, 0, 0),        0, 1, 28, 0,   0, 0,   23};
        vecs[3] = '{1, 2, 2, 2,  2, 2,  2, pack6(1, 2, 3, 4, 0, 0),         0, 1, 28, 5,   0, 0,   23};
        vecs[4] = '{0, 1, 5, 1,  1, 1,  1, pack6(1, 2, 3, 4, 5, 0),         0, 0, 0,  0,   0, 0,   13};
        vecs[5] = '{0, 3, 2, 1,  2, -1, 0, pack6(5, 7, 9, 11, 2, 4),        0, 2, 30, 10,  31, 29, 33};
        vecs[6] = '{1, 2, 2, -3, 0, 0,  0, pack6(5, 0, 0, 0, 0, 0),         0, 1, 28, 0,   0, 0,   23};
        vecs[7] = '{1, 5, 1, 1,  1, 1,  1, pack6(9, 9, 9, 9, 9, 0),         1, 0, 0,  0,   0, 0,   13};
        vecs[8] = '{0, 0, 0, 1,  1, 1,  1, pack6(0, 0, 0, 0, 0, 0),         0, 0, 0,  0,   0, 0,   13};

        start_s[0] = 1'b0;
        start_s[1] = 1'b0;

        // Reset values must appear without any clock edge.
        #1 rst = 1'b0;
        #1 idle_outputs("reset_state");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_without_start", busy_s[0], 0);

        for (int v = 0; v < NV; v++) begin
            cur_k[0] = vecs[v].k0; cur_k[1] = vecs[v].k1;
            cur_k[2] = vecs[v].k2; cur_k[3] = vecs[v].k3;
            for (int i = 0; i < 64; i++) img[i] = 0;
            for (int i = 0; i < 6; i++) img[i] = int'(vecs[v].px[i]);
            exp_q.delete();
            if (vecs[v].nexp > 0) exp_q.push_back('{vecs[v].inst, vecs[v].a0, vecs[v].d0});
            if (vecs[v].nexp > 1) exp_q.push_back('{vecs[v].inst, vecs[v].a1, vecs[v].d1});
            load_and_start(vecs[v].inst, vecs[v].m, vecs[v].n);
            wait_done(vecs[v].inst, vecs[v].noisy, dc);
            check_pass($sformatf("vec%0d", v), dc, vecs[v].done_cyc);
        end

        // Abort inside the first pixel's write cycle: WE must rise at once, nothing logged.
        cur_k = '{1, 1, 1, 1};
        for (int i = 0; i < 64; i++) img[i] = 100;
        load_and_start(0, 2, 3);
        repeat (22) @(negedge clk);
        check("in_write_cycle", we_s[0], 0);
        #1 rst = 1'b0;
        #1 idle_outputs("abort_wr");
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("abort_wr_stays_idle", busy_s[0], 0);
        check("abort_wr_no_write", wq.size() - wq_base, 0);

        // Abort during the second pixel's PIX_CAP: only the first pixel was written.
        load_and_start(0, 2, 3);
        repeat (24) @(negedge clk);
        #1 rst = 1'b0;
        #1 idle_outputs("abort_cap");
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("abort_cap_stays_idle", busy_s[0], 0);
        check("abort_cap_n_writes", wq.size() - wq_base, 1);
        if (wq.size() > wq_base) begin
            check("abort_cap_wr_addr", wq[wq_base].addr, 30);
            check("abort_cap_wr_data", wq[wq_base].data, 255);
        end

        // Restart after the abort with a fresh image.
        cur_k = '{2, -1, 3, 1};
        for (int i = 0; i < 64; i++) img[i] = $urandom_range(0, 60);
        ed = model(0, 3, 4, 0);
        load_and_start(0, 3, 4);
        wait_done(0, 1'b1, dc);
        check_pass("restart", dc, ed);

        for (int t = 0; t < 12; t++) begin
            inst = t % 2;
            m    = (t % 5 == 4) ? $urandom_range(0, 1) : $urandom_range(2, 5);
            n    = $urandom_range(1, 6);
            for (int j = 0; j < 4; j++) begin
                cur_k[j] = (t % 3 == 0) ? int'($urandom_range(0, 65535)) - 32768
                                        : int'($urandom_range(0, 8)) - 4;
            end
            for (int i = 0; i < 64; i++) img[i] = $urandom_range(0, 255);
            ed = model(inst, m, n, inst == 1 ? 2 : 0);
            load_and_start(inst, m, n);
            wait_done(inst, t[0], dc);
            check_pass($sformatf("rand%0d", t), dc, ed);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
